// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, the hard-wired
// zero register and the NOP encoding. Also provides the dependency-match helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_e;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP      = 32'd0;

    // Destination register $0 is never a real producer, so it never matches.
    function automatic logic reg_match(input logic [4:0] dst,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return (dst != REG_ZERO) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard compare for the instruction in ID. The load-use,
// branch-vs-ALU-in-EX and branch-vs-load-in-MEM terms are ORed into hz_o.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       uses_rt_i,
    input  logic       branch_i,
    input  logic       idex_memread_i,
    input  logic       idex_regwrite_i,
    input  logic [4:0] idex_regdst_i,
    input  logic       exmem_memread_i,
    input  logic [4:0] exmem_regdst_i,
    output logic       hz_o
);

    logic idex_match;
    logic exmem_match;

    // Compare each older producer against the ID-stage sources and merge the terms.
    always_comb begin
        idex_match  = reg_match(idex_regdst_i,  rs_i, rt_i, uses_rt_i);
        exmem_match = reg_match(exmem_regdst_i, rs_i, rt_i, uses_rt_i);
        hz_o = (idex_memread_i  & idex_match)
             | (branch_i & idex_regwrite_i & idex_match)
             | (branch_i & exmem_memread_i & exmem_match);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer: advance, bubble ID/EX, freeze on data-memory
// stall, or flush IF/ID on a taken branch/jump. Enables are combinational from
// the current inputs; state, stall counter and the sticky error are registered.
// Optional feature: define HAZARD_PERF_EN to add saturating bubble/freeze/flush
// counters (perf_stall_o, perf_freeze_o, perf_flush_o).
// Handshake note: there is no valid/ready pair here; each enable is a
// per-cycle level that the pipeline registers sample on the next clk_i edge.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 3
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IFIDrsaddr,
    input  logic [4:0]       IFIDrtaddr,
    input  logic             IFIDusesrt,
    input  logic             IFIDbranch,
    input  logic             IDEXmemread,
    input  logic             IDEXregwrite,
    input  logic [4:0]       IDEXregdst,
    input  logic             EXMEMmemread,
    input  logic [4:0]       EXMEMregdst,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             mem_stall_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_en_o,
    output logic             hazard_err_o,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] perf_stall_o,
    output logic [CNT_W-1:0] perf_freeze_o,
    output logic [CNT_W-1:0] perf_flush_o,
`endif
    output state_e           state_dbg_o
);

    localparam int            CW      = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STALL);

    state_e        state_q, state_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          err_q, err_d;
    logic          hz;

    hazard_detect u_detect (
        .rs_i            (IFIDrsaddr),
        .rt_i            (IFIDrtaddr),
        .uses_rt_i       (IFIDusesrt),
        .branch_i        (IFIDbranch),
        .idex_memread_i  (IDEXmemread),
        .idex_regwrite_i (IDEXregwrite),
        .idex_regdst_i   (IDEXregdst),
        .exmem_memread_i (EXMEMmemread),
        .exmem_regdst_i  (EXMEMregdst),
        .hz_o            (hz)
    );

    // State register, stall counter and sticky error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    // Next state: freeze holds the counter, a bubble counts up (saturating), a clean cycle clears it.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q;
        if (mem_stall_i) begin
            state_d = ST_FREEZE;
        end else if (hz) begin
            state_d     = ST_STALL;
            stall_cnt_d = (stall_cnt_q >= CNT_MAX) ? CNT_MAX : stall_cnt_q + 1'b1;
        end else begin
            state_d     = ST_RUN;
            stall_cnt_d = '0;
        end
        if (stall_cnt_d == CNT_MAX) begin
            err_d = 1'b1;
        end
    end

    // Enables: reset forces RUN values immediately; otherwise mem stall > hazard > flush.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_en_o     = 1'b1;
        if (!rst_i) begin
            if (mem_stall_i) begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                pipe_en_o    = 1'b0;
            end else if (hz) begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                idex_bubble_o = 1'b1;
            end else begin
                ifid_flush_o = (branch_taken_i & IFIDbranch) | jump_i;
            end
        end
    end

    assign hazard_err_o = err_q;
    assign state_dbg_o  = state_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_stall_q, perf_freeze_q, perf_flush_q;

    // Saturating event counters for bubbles, freeze cycles and IF/ID flushes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_stall_q  <= '0;
            perf_freeze_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (idex_bubble_o && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
            if (mem_stall_i && (perf_freeze_q != '1)) perf_freeze_q <= perf_freeze_q + 1'b1;
            if (ifid_flush_o && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 1'b1;
        end
    end

    assign perf_stall_o  = perf_stall_q;
    assign perf_freeze_o = perf_freeze_q;
    assign perf_flush_o  = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, load+branch, $0 immunity, freeze,
// jump flush, branch-vs-ALU, error threshold, reset mid-stall, freeze hold.
module tb_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] IFIDrsaddr, IFIDrtaddr, IDEXregdst, EXMEMregdst;
    logic       IFIDusesrt, IFIDbranch, IDEXmemread, IDEXregwrite, EXMEMmemread;
    logic       branch_taken_i, jump_i, mem_stall_i;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_en_o, hazard_err_o;
    state_e     state_dbg_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_o, perf_freeze_o, perf_flush_o;
`endif

    int errs   = 0;
    int checks = 0;

    hazard_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .IFIDrsaddr     (IFIDrsaddr),
        .IFIDrtaddr     (IFIDrtaddr),
        .IFIDusesrt     (IFIDusesrt),
        .IFIDbranch     (IFIDbranch),
        .IDEXmemread    (IDEXmemread),
        .IDEXregwrite   (IDEXregwrite),
        .IDEXregdst     (IDEXregdst),
        .EXMEMmemread   (EXMEMmemread),
        .EXMEMregdst    (EXMEMregdst),
        .branch_taken_i (branch_taken_i),
        .jump_i         (jump_i),
        .mem_stall_i    (mem_stall_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .pipe_en_o      (pipe_en_o),
        .hazard_err_o   (hazard_err_o),
`ifdef HAZARD_PERF_EN
        .perf_stall_o   (perf_stall_o),
        .perf_freeze_o  (perf_freeze_o),
        .perf_flush_o   (perf_flush_o),
`endif
        .state_dbg_o    (state_dbg_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all five enables against hand-derived values.
    task automatic expect_out(input string tag, input logic pc, input logic ifid,
                              input logic fl, input logic bub, input logic pe);
        chk({tag, ".pc_write"},   32'(pc_write_o),    32'(pc));
        chk({tag, ".ifid_write"}, 32'(ifid_write_o),  32'(ifid));
        chk({tag, ".flush"},      32'(ifid_flush_o),  32'(fl));
        chk({tag, ".bubble"},     32'(idex_bubble_o), 32'(bub));
        chk({tag, ".pipe_en"},    32'(pipe_en_o),     32'(pe));
    endtask

    task automatic idle();
        IFIDrsaddr = 5'd0; IFIDrtaddr = 5'd0; IFIDusesrt = 1'b0; IFIDbranch = 1'b0;
        IDEXmemread = 1'b0; IDEXregwrite = 1'b0; IDEXregdst = 5'd0;
        EXMEMmemread = 1'b0; EXMEMregdst = 5'd0;
        branch_taken_i = 1'b0; jump_i = 1'b0; mem_stall_i = 1'b0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Load in EX writing dst, consumer in ID reading rs
    task automatic load_use(input logic [4:0] dst);
        IDEXmemread = 1'b1; IDEXregwrite = 1'b1; IDEXregdst = dst; IFIDrsaddr = dst;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        #1;
        expect_out("reset", 1, 1, 0, 0, 1);
        chk("reset.err", 32'(hazard_err_o), 0);
        chk("reset.state", 32'(state_dbg_o), 32'(ST_RUN));
        tick(); tick();
        rst_i = 1'b0;
        #1;

        // 1: lw $2 in EX, add rs=$2 in ID -> one bubble
        load_use(5'd2);
        #1 expect_out("t1.bubble", 0, 0, 0, 1, 1);
        tick();
        chk("t1.state", 32'(state_dbg_o), 32'(ST_STALL));
        idle(); IFIDrsaddr = 5'd2; EXMEMmemread = 1'b1; EXMEMregdst = 5'd2;
        #1 expect_out("t1.resume", 1, 1, 0, 0, 1);
        tick();
        chk("t1.run", 32'(state_dbg_o), 32'(ST_RUN));

        // 2: lw $3 in EX, beq rt=$3 in ID -> two bubbles, then taken flush
        idle(); IFIDbranch = 1'b1; IFIDusesrt = 1'b1; IFIDrsaddr = 5'd5; IFIDrtaddr = 5'd3;
        IDEXmemread = 1'b1; IDEXregwrite = 1'b1; IDEXregdst = 5'd3;
        #1 expect_out("t2.b1", 0, 0, 0, 1, 1);
        tick();
        IDEXmemread = 1'b0; IDEXregwrite = 1'b0; IDEXregdst = 5'd0;
        EXMEMmemread = 1'b1; EXMEMregdst = 5'd3;
        #1 expect_out("t2.b2", 0, 0, 0, 1, 1);
        tick();
        EXMEMmemread = 1'b0; EXMEMregdst = 5'd0; branch_taken_i = 1'b1;
        #1 expect_out("t2.flush", 1, 1, 1, 0, 1);
        tick();
        chk("t2.err", 32'(hazard_err_o), 0);
        chk("t2.state", 32'(state_dbg_o), 32'(ST_RUN));

        // 3: $0 never matches
        idle(); IDEXmemread = 1'b1; IDEXregdst = 5'd0; IFIDrsaddr = 5'd0;
        #1 expect_out("t3.zero", 1, 1, 0, 0, 1);
        tick();

        // 4: mem stall over a load-use for 4 cycles, then one bubble
        idle(); load_use(5'd9); mem_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 expect_out("t4.freeze", 0, 0, 0, 0, 0);
            tick();
        end
        chk("t4.state", 32'(state_dbg_o), 32'(ST_FREEZE));
        mem_stall_i = 1'b0;
        #1 expect_out("t4.after", 0, 0, 0, 1, 1);
        tick();

        // 5: jump flushes, unless memory is stalled
        idle(); jump_i = 1'b1;
        #1 expect_out("t5.jump", 1, 1, 1, 0, 1);
        tick();
        mem_stall_i = 1'b1;
        #1 expect_out("t5.jump_stall", 0, 0, 0, 0, 0);
        tick();
        idle();
`ifdef HAZARD_PERF_EN
        chk("perf.stall",  perf_stall_o,  32'd4);
        chk("perf.freeze", perf_freeze_o, 32'd5);
        chk("perf.flush",  perf_flush_o,  32'd2);
`endif
        tick();

        // 8: branch vs ALU result in EX stalls; non-branch consumer does not; rt ignored when unused
        IFIDbranch = 1'b1; IDEXregwrite = 1'b1; IDEXregdst = 5'd7; IFIDrsaddr = 5'd7;
        #1 expect_out("t8.br_alu", 0, 0, 0, 1, 1);
        tick();
        IFIDbranch = 1'b0;
        #1 expect_out("t8.alu_fwd", 1, 1, 0, 0, 1);
        tick();
        idle(); IDEXmemread = 1'b1; IDEXregdst = 5'd4; IFIDrtaddr = 5'd4; IFIDrsaddr = 5'd1;
        #1 expect_out("t8.no_rt", 1, 1, 0, 0, 1);
        tick();

        // 6: three consecutive bubbles latch the error; reset mid-stall clears at once
        idle(); load_use(5'd6);
        tick();
        chk("t6.err1", 32'(hazard_err_o), 0);
        tick();
        chk("t6.err2", 32'(hazard_err_o), 0);
        tick();
        chk("t6.err3", 32'(hazard_err_o), 1);
        idle();
        tick();
        chk("t6.sticky", 32'(hazard_err_o), 1);
        load_use(5'd6);
        #1 expect_out("t6.stalled", 0, 0, 0, 1, 1);
        rst_i = 1'b1;
        #1 expect_out("t6.rst", 1, 1, 0, 0, 1);
        chk("t6.rst_err", 32'(hazard_err_o), 0);
        chk("t6.rst_state", 32'(state_dbg_o), 32'(ST_RUN));
        tick();
        idle(); rst_i = 1'b0;
        tick();

        // 7: freeze holds the stall count
        load_use(5'd8);
        tick(); tick();
        chk("t7.err_pre", 32'(hazard_err_o), 0);
        mem_stall_i = 1'b1;
        tick();
        chk("t7.err_frz", 32'(hazard_err_o), 0);
        mem_stall_i = 1'b0;
        tick();
        chk("t7.err_post", 32'(hazard_err_o), 1);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
